// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN              default address/PC width
//   OPC_*             RV32I major opcodes seen in the instruction stream
//   FETCH_FAULT_WORD  data word carried by fault entries
//   fetch_state_t     fetch sequencer states
//   pc_misaligned()   true when a PC cannot address a 32-bit word
package instr_fetch_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6f;

   localparam logic [31:0] FETCH_FAULT_WORD = 32'h0;

   // FETCH: nothing outstanding, WAIT: one request outstanding,
   // DRAIN: outstanding response is stale, HALT: fault queued.
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

   function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
      return pc_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle around the fetch unit: instruction memory request/response,
// branch/jump redirect, and the decode-side instruction handshake.
//   master : the fetch unit (drives imem_req_*, inst_*)
//   slave  : memory + decode + branch resolution (drives the rest)
interface instr_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [31:0]     imem_resp_data;
   logic            imem_resp_err;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst_pc;
   logic [31:0]     inst_data;
   logic [6:0]      inst_opcode;
   logic [2:0]      inst_funct3;
   logic [6:0]      inst_funct7;
   logic            inst_fault;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
      input  redirect_valid, redirect_pc,
      output inst_valid, inst_pc, inst_data, inst_opcode, inst_funct3, inst_funct7, inst_fault,
      input  inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
      output redirect_valid, redirect_pc,
      input  inst_valid, inst_pc, inst_data, inst_opcode, inst_funct3, inst_funct7, inst_fault,
      output inst_ready
   );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous instruction buffer.
//   clk, rst   clock, synchronous active-high reset (pointers/count only)
//   flush      empties the buffer; dominates push and pop
//   push, din  write one entry
//   pop        release the head entry (ignored when empty)
//   head       head entry (stale when count is zero)
//   count      number of valid entries
module instr_fetch_unit_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push,
   input  logic [WIDTH-1:0]        din,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = count == (AW+1)'(DEPTH);
   assign do_pop  = pop && (count != '0);
   // A push into a full buffer is only taken when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage carries no reset; validity comes from count.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: producer side of the decode interface.
// Holds the PC, issues at most one instruction-memory request at a time,
// buffers fetched words (or fault entries) and presents the buffer head to
// decode with the RV32I opcode/funct3/funct7 fields pre-sliced.
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   bus  instr_fetch_unit_if.master: imem_req_*/imem_resp_*, redirect_*, inst_*
module instr_fetch_unit #(
   parameter int              XLEN       = instr_fetch_unit_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   instr_fetch_unit_if.master  bus
);
   import instr_fetch_unit_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = XLEN + 33;   // {pc, data, fault}

   fetch_state_t    state;
   fetch_state_t    state_n;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_n;

   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_flush;
   logic [EW-1:0]   fifo_din;
   logic [EW-1:0]   fifo_head;
   logic [CW-1:0]   fifo_count;

   logic            slot_free;
   logic            req_valid;
   logic            head_valid;
   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_data;
   logic            head_fault;

   // A buffer slot is reserved when a request issues, so the response always has room.
   assign slot_free = fifo_count < CW'(FIFO_DEPTH);
   assign req_valid = !rst && (state == ST_FETCH) && slot_free &&
                      !pc_misaligned(pc[1:0]) && !bus.redirect_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FETCH;
         pc    <= RESET_PC;
      end else begin
         state <= state_n;
         pc    <= pc_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      fifo_din   = {pc, FETCH_FAULT_WORD, 1'b1};

      if (bus.redirect_valid) begin
         // Redirect wins over everything; a response landing this cycle is dropped,
         // otherwise an outstanding request must be drained before refetching.
         fifo_flush = 1'b1;
         pc_n       = bus.redirect_pc;
         if ((state == ST_WAIT || state == ST_DRAIN) && !bus.imem_resp_valid)
            state_n = ST_DRAIN;
         else
            state_n = ST_FETCH;
      end else begin
         case (state)
            ST_FETCH: begin
               if (pc_misaligned(pc[1:0])) begin
                  if (slot_free) begin
                     fifo_push = 1'b1;
                     state_n   = ST_HALT;
                  end
               end else if (req_valid && bus.imem_req_ready) begin
                  state_n = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.imem_resp_valid) begin
                  fifo_push = 1'b1;
                  if (bus.imem_resp_err) begin
                     state_n = ST_HALT;
                  end else begin
                     fifo_din = {pc, bus.imem_resp_data, 1'b0};
                     pc_n     = pc + XLEN'(4);
                     state_n  = ST_FETCH;
                  end
               end
            end
            ST_DRAIN: begin
               if (bus.imem_resp_valid) state_n = ST_FETCH;
            end
            ST_HALT: begin
               state_n = ST_HALT;
            end
            default: begin
               state_n = ST_FETCH;
            end
         endcase
      end
   end

   instr_fetch_unit_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .count (fifo_count)
   );

   assign {head_pc, head_data, head_fault} = fifo_head;
   assign head_valid = !rst && (fifo_count != '0);
   assign fifo_pop   = head_valid && bus.inst_ready;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = rst ? RESET_PC : pc;

   // Head fields are forced to zero whenever no entry is presented.
   assign bus.inst_valid  = head_valid;
   assign bus.inst_pc     = head_valid ? head_pc : '0;
   assign bus.inst_data   = head_valid ? head_data : 32'h0;
   assign bus.inst_fault  = head_valid && head_fault;
   assign bus.inst_opcode = head_valid ? head_data[6:0]   : 7'h0;
   assign bus.inst_funct3 = head_valid ? head_data[14:12] : 3'h0;
   assign bus.inst_funct7 = head_valid ? head_data[31:25] : 7'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        fault;
   } ent_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   // memory model controls
   int          mem_lat      = 1;
   bit          mem_lat_rand = 0;
   bit          mem_rdy_rand = 0;
   bit          mem_keep     = 0;
   bit          err_en       = 0;
   logic [31:0] err_addr     = 32'h0;
   int          overlap      = 0;

   logic [31:0] req_log [$];
   ent_t        got [$];

   instr_fetch_unit_if #(.XLEN(32)) bus ();

   instr_fetch_unit #(
      .XLEN       (32),
      .RESET_PC   (32'h0),
      .FIFO_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return 32'h00500093 ^ {a[9:0], 7'h0, a[4:2], 12'h0};
   endfunction

   // Memory: responses driven at negedge+1, acceptance observed at negedge+2.
   initial begin
      bit          pend;
      int          cnt;
      logic [31:0] paddr;
      pend = 0; cnt = 0; paddr = 0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.imem_resp_err   = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = 32'h0;
         bus.imem_resp_err   = 1'b0;
         if (rst && !mem_keep) pend = 0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               bus.imem_resp_valid = 1'b1;
               bus.imem_resp_data  = memword(paddr);
               bus.imem_resp_err   = err_en && (paddr == err_addr);
               pend = 0;
            end
         end
         bus.imem_req_ready = mem_rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
         #1;
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            if (pend) overlap++;
            pend  = 1;
            cnt   = mem_lat_rand ? $urandom_range(1, 4) : mem_lat;
            paddr = bus.imem_req_addr;
            req_log.push_back(bus.imem_req_addr);
         end
      end
   end

   // Decode-side monitor: records every completed transfer.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (!rst && bus.inst_valid && bus.inst_ready)
            got.push_back('{bus.inst_pc, bus.inst_data, bus.inst_fault});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   // Holds reset for two cycles; returns at sample point of the first cycle after release.
   task automatic do_reset(input int lat);
      @(negedge clk);
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.inst_ready     = 1'b0;
      mem_lat = lat; mem_lat_rand = 0; mem_rdy_rand = 0; err_en = 0; mem_keep = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_log.delete();
      got.delete();
      #3;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid); end
         checks++; if (bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr: got %h expected 0", bus.imem_req_addr); end
         checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b expected 0", bus.inst_valid); end
         checks++; if ({bus.inst_pc, bus.inst_data, bus.inst_fault} !== 65'h0) begin errors++; $display("FAIL rst_inst_fields: got %h/%h/%b expected 0", bus.inst_pc, bus.inst_data, bus.inst_fault); end
      end
      @(negedge clk);
      rst = 1'b0;
      #3;
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %b expected 1", bus.imem_req_valid); end
      checks++; if (bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_first_addr: got %h expected 0", bus.imem_req_addr); end
   endtask

   task automatic test_stream();
      do_reset(1);
      bus.inst_ready = 1'b1;
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL stream_c0_req: got %b@%h expected 1@0", bus.imem_req_valid, bus.imem_req_addr); end
      for (int c = 1; c < 20; c++) begin
         step();
         checks++; if (bus.inst_valid !== (c >= 2 && c % 2 == 0)) begin errors++; $display("FAIL stream_rate c%0d: got %b expected %b", c, bus.inst_valid, (c >= 2 && c % 2 == 0)); end
         if (c == 2) begin
            checks++; if (bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h00500093) begin errors++; $display("FAIL stream_first: got %h/%h expected 0/00500093", bus.inst_pc, bus.inst_data); end
            checks++; if (bus.inst_opcode !== OPC_OP_IMM || bus.inst_funct3 !== 3'h0 || bus.inst_funct7 !== 7'h0) begin errors++; $display("FAIL stream_fields: got %h/%h/%h expected 13/0/0", bus.inst_opcode, bus.inst_funct3, bus.inst_funct7); end
            checks++; if (bus.inst_fault !== 1'b0) begin errors++; $display("FAIL stream_fault: got %b expected 0", bus.inst_fault); end
         end
      end
      checks++; if (got.size() != 9) begin errors++; $display("FAIL stream_count: got %0d expected 9", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         checks++; if (got[i] !== ent_t'({32'(4 * i), memword(32'(4 * i)), 1'b0})) begin errors++; $display("FAIL stream_entry %0d: got %h expected pc %h", i, got[i], 4 * i); end
      end
      checks++; if (req_log.size() != 10) begin errors++; $display("FAIL stream_req_count: got %0d expected 10", req_log.size()); end
      for (int i = 0; i < req_log.size(); i++) begin
         checks++; if (req_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_req_addr %0d: got %h expected %h", i, req_log[i], 4 * i); end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1);
      repeat (11) step();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got %b@%h expected 1@0", bus.inst_valid, bus.inst_pc); end
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stall: got %b expected 0", bus.imem_req_valid); end
      checks++; if (req_log.size() != 2) begin errors++; $display("FAIL bp_req_count: got %0d expected 2", req_log.size()); end
      @(negedge clk); bus.inst_ready = 1'b1; #3;
      checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL bp_pop_head: got %h expected 0", bus.inst_pc); end
      @(negedge clk); bus.inst_ready = 1'b0; #3;
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4) begin errors++; $display("FAIL bp_second: got %b@%h expected 1@4", bus.inst_valid, bus.inst_pc); end
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8) begin errors++; $display("FAIL bp_resume: got %b@%h expected 1@8", bus.imem_req_valid, bus.imem_req_addr); end
   endtask

   task automatic test_redirect_wait();
      do_reset(3);
      @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; #3;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_c1_req: got %b expected 0", bus.imem_req_valid); end
      @(negedge clk); bus.redirect_valid = 1'b0; #3;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_c2_req: got %b expected 0", bus.imem_req_valid); end
      step();
      checks++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_c3: got req %b inst %b expected 0/0", bus.imem_req_valid, bus.inst_valid); end
      @(negedge clk); bus.inst_ready = 1'b1; mem_lat = 1; #3;
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin errors++; $display("FAIL rdw_refetch: got %b@%h expected 1@100", bus.imem_req_valid, bus.imem_req_addr); end
      checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_dropped: got %b expected 0", bus.inst_valid); end
      step();
      step();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst_data !== memword(32'h100)) begin errors++; $display("FAIL rdw_new_inst: got %b@%h data %h expected 1@100 data %h", bus.inst_valid, bus.inst_pc, bus.inst_data, memword(32'h100)); end
   endtask

   task automatic test_misaligned();
      do_reset(1);
      step();
      @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h102; #3;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_withdraw: got %b expected 0", bus.imem_req_valid); end
      @(negedge clk); bus.redirect_valid = 1'b0; #3;
      checks++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL mis_flush: got req %b inst %b expected 0/0", bus.imem_req_valid, bus.inst_valid); end
      step();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_fault !== 1'b1 || bus.inst_pc !== 32'h102) begin errors++; $display("FAIL mis_fault_entry: got %b/%b@%h expected 1/1@102", bus.inst_valid, bus.inst_fault, bus.inst_pc); end
      checks++; if (bus.inst_data !== 32'h0 || bus.inst_opcode !== 7'h0) begin errors++; $display("FAIL mis_fault_data: got %h expected 0", bus.inst_data); end
      repeat (3) step();
      checks++; if (bus.imem_req_valid !== 1'b0 || req_log.size() != 1) begin errors++; $display("FAIL mis_halt: got req %b count %0d expected 0/1", bus.imem_req_valid, req_log.size()); end
      @(negedge clk); bus.inst_ready = 1'b1; #3;
      @(negedge clk); bus.inst_ready = 1'b0; #3;
      checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_popped: got inst %b req %b expected 0/0", bus.inst_valid, bus.imem_req_valid); end
      @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; #3;
      @(negedge clk); bus.redirect_valid = 1'b0; #3;
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin errors++; $display("FAIL mis_resume: got %b@%h expected 1@200", bus.imem_req_valid, bus.imem_req_addr); end
   endtask

   task automatic test_bus_error();
      do_reset(1);
      err_en = 1; err_addr = 32'h8;
      bus.inst_ready = 1'b1;
      repeat (15) step();
      checks++; if (got.size() != 3) begin errors++; $display("FAIL berr_count: got %0d expected 3", got.size()); end
      else begin
         checks++; if (got[0].pc !== 32'h0 || got[1].pc !== 32'h4 || got[0].fault || got[1].fault) begin errors++; $display("FAIL berr_good: got %h %h expected pc 0,4 no fault", got[0], got[1]); end
         checks++; if (got[2] !== ent_t'({32'h8, 32'h0, 1'b1})) begin errors++; $display("FAIL berr_fault: got %h expected pc 8 data 0 fault 1", got[2]); end
      end
      checks++; if (req_log.size() != 3 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL berr_halt: got %0d reqs, req %b expected 3/0", req_log.size(), bus.imem_req_valid); end
      @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; #3;
      @(negedge clk); bus.redirect_valid = 1'b0; #3;
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h40) begin errors++; $display("FAIL berr_resume: got %b@%h expected 1@40", bus.imem_req_valid, bus.imem_req_addr); end
   endtask

   task automatic test_mid_reset();
      do_reset(1);
      step();
      @(negedge clk); mem_lat = 4; mem_keep = 1; #3;
      @(negedge clk); rst = 1'b1; #3;
      checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL mrst_during: got inst %b req %b@%h expected 0 0@0", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
      step();
      checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL mrst_next: got %b expected 0", bus.inst_valid); end
      step();
      @(negedge clk); rst = 1'b0; mem_lat = 1; bus.inst_ready = 1'b1; #3;
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL mrst_release: got req %b@%h inst %b expected 1@0 0", bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid); end
      @(negedge clk); mem_keep = 0; #3;
      checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL mrst_late_ignored: got %b@%h expected 0", bus.inst_valid, bus.inst_pc); end
      step();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_data !== memword(32'h0) || bus.inst_fault !== 1'b0) begin errors++; $display("FAIL mrst_refetch: got %b@%h data %h expected 1@0 data %h", bus.inst_valid, bus.inst_pc, bus.inst_data, memword(32'h0)); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         ent_t        exp [$];
         logic [31:0] eaddr;
         logic [31:0] p;
         do_reset(1);
         mem_lat_rand = 1; mem_rdy_rand = 1; overlap = 0;
         eaddr = 32'(4 * $urandom_range(2, 12));
         err_en = (it % 2) == 1; err_addr = eaddr;
         // Expected stream: sequential words from 0 until the first bus error.
         for (int i = 0; i < 128; i++) begin
            p = 32'(4 * i);
            if (err_en && p == eaddr) begin
               exp.push_back('{p, 32'h0, 1'b1});
               break;
            end
            exp.push_back('{p, memword(p), 1'b0});
         end
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            bus.inst_ready = ($urandom_range(0, 1) == 1);
         end
         @(negedge clk); bus.inst_ready = 1'b0; #3;
         checks++; if (got.size() == 0 || got.size() > exp.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected 1..%0d", it, got.size(), exp.size()); end
         for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rand%0d_entry %0d: got %h expected %h", it, i, got[i], exp[i]); end
         end
         for (int i = 0; i < req_log.size() && i < exp.size(); i++) begin
            checks++; if (req_log[i] !== exp[i].pc) begin errors++; $display("FAIL rand%0d_req %0d: got %h expected %h", it, i, req_log[i], exp[i].pc); end
         end
         checks++; if (overlap != 0) begin errors++; $display("FAIL rand%0d_outstanding: got %0d overlapping requests expected 0", it, overlap); end
         if (err_en) begin
            checks++; if (got.size() != exp.size() || req_log.size() != exp.size() || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rand%0d_halt: got %0d entries %0d reqs req %b expected %0d %0d 0", it, got.size(), req_log.size(), bus.imem_req_valid, exp.size(), exp.size()); end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.inst_ready     = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_misaligned();
      test_bus_error();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
